// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: addresses, response codes,
// writable-bit masks and the read-channel state encoding.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   localparam logic [1:0] RRESP_OK      = 2'b00;
   localparam logic [1:0] RRESP_ILLEGAL = 2'b10;

   localparam logic [31:0] MSTATUS_WMASK = 32'h0000_0088;
   localparam logic [31:0] MSTATUS_RO   = 32'h0000_1800;
   localparam logic [31:0] MIE_WMASK     = 32'h0000_0888;

   typedef enum logic [1:0] {
      RD_IDLE  = 2'd0,
      RD_COUNT = 2'd1,
      RD_RESP  = 2'd2,
      RD_HOLD  = 2'd3
   } rd_state_t;

   // The top two address bits equal to 2'b11 mark the read-only CSR space.
   function automatic logic is_read_only(input logic [11:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// CSR read bus between the execute-stage CSR unit (master) and the CSR file (slave).
interface csr_file_if;
   logic [11:0] csrbus_araddr;
   logic        csrbus_arvalid;
   logic [31:0] csrbus_rdata;
   logic [1:0]  csrbus_rresp;
   logic        csrbus_rvalid;

   modport master (
      output csrbus_araddr, csrbus_arvalid,
      input  csrbus_rdata, csrbus_rresp, csrbus_rvalid
   );

   modport slave (
      input  csrbus_araddr, csrbus_arvalid,
      output csrbus_rdata, csrbus_rresp, csrbus_rvalid
   );
endinterface

// File: rtl/csr_counter64.sv
// 64-bit performance counter; a write to either half takes priority over the
// increment in the same cycle, and only increments carry into the high half.
module csr_counter64 (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_inc,
   input  logic        i_wr_lo,
   input  logic        i_wr_hi,
   input  logic [31:0] i_wdata,
   output logic [63:0] o_count
);
   logic [63:0] r_count;

   // Counter state: half-writes first, then increment.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= 64'd0;
      end else if (i_wr_lo) begin
         r_count[31:0] <= i_wdata;
      end else if (i_wr_hi) begin
         r_count[63:32] <= i_wdata;
      end else if (i_inc) begin
         r_count <= r_count + 64'd1;
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file with a latency-programmable read channel and a single-cycle
// write port. Define CSR_COUNTERS_EN to add the 64-bit mcycle/minstret counters.
module csr_file
   import csr_pkg::*;
#(
   parameter int          READ_LATENCY = 1,
   parameter logic [31:0] HART_ID      = 32'd0,
   parameter logic [31:0] MISA_VAL     = 32'h4000_0100
) (
   input  logic        clk,
   input  logic        reset_n,
   csr_file_if.slave   csrbus,
   input  logic [11:0] csr_write_addr,
   input  logic [31:0] csr_write_val,
   input  logic        csr_write_valid,
   input  logic        instret_inc,
   output logic [31:0] mtvec_out,
   output logic [31:0] mepc_out
);
   localparam logic [2:0] LAT_M1 = 3'(READ_LATENCY - 1);

   rd_state_t   r_state;
   logic [2:0]  r_cnt;
   logic [11:0] r_addr;
   logic        r_rvalid;

   logic [31:0] r_mstatus, r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;

   logic        w_wr_en;
   logic [31:0] w_rd_data;
   logic        w_rd_legal;

   assign w_wr_en = csr_write_valid && !is_read_only(csr_write_addr);

`ifdef CSR_COUNTERS_EN
   logic [63:0] w_mcycle, w_minstret;

   csr_counter64 u_mcycle (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (1'b1),
      .i_wr_lo (w_wr_en && (csr_write_addr == CSR_MCYCLE)),
      .i_wr_hi (w_wr_en && (csr_write_addr == CSR_MCYCLEH)),
      .i_wdata (csr_write_val),
      .o_count (w_mcycle)
   );

   csr_counter64 u_minstret (
      .clk     (clk),
      .reset_n (reset_n),
      .i_inc   (instret_inc),
      .i_wr_lo (w_wr_en && (csr_write_addr == CSR_MINSTRET)),
      .i_wr_hi (w_wr_en && (csr_write_addr == CSR_MINSTRETH)),
      .i_wdata (csr_write_val),
      .o_count (w_minstret)
   );
`else
   logic w_unused_instret;
   assign w_unused_instret = instret_inc;
`endif

   // Architectural register updates from the write port.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_mstatus  <= 32'd0;
         r_mie      <= 32'd0;
         r_mtvec    <= 32'd0;
         r_mscratch <= 32'd0;
         r_mepc     <= 32'd0;
         r_mcause   <= 32'd0;
         r_mtval    <= 32'd0;
      end else if (w_wr_en) begin
         case (csr_write_addr)
            CSR_MSTATUS:  r_mstatus  <= csr_write_val & MSTATUS_WMASK;
            CSR_MIE:      r_mie      <= csr_write_val & MIE_WMASK;
            CSR_MTVEC:    r_mtvec    <= {csr_write_val[31:2], 2'b00};
            CSR_MSCRATCH: r_mscratch <= csr_write_val;
            CSR_MEPC:     r_mepc     <= {csr_write_val[31:2], 2'b00};
            CSR_MCAUSE:   r_mcause   <= csr_write_val;
            CSR_MTVAL:    r_mtval    <= csr_write_val;
            default:      ;
         endcase
      end
   end

   // Read mux on the latched address; reflects current register state so a
   // same-cycle write is not yet visible.
   always_comb begin
      w_rd_data  = 32'd0;
      w_rd_legal = 1'b1;
      case (r_addr)
         CSR_MSTATUS:  w_rd_data = r_mstatus | MSTATUS_RO;
         CSR_MISA:     w_rd_data = MISA_VAL;
         CSR_MIE:      w_rd_data = r_mie;
         CSR_MTVEC:    w_rd_data = r_mtvec;
         CSR_MSCRATCH: w_rd_data = r_mscratch;
         CSR_MEPC:     w_rd_data = r_mepc;
         CSR_MCAUSE:   w_rd_data = r_mcause;
         CSR_MTVAL:    w_rd_data = r_mtval;
         CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_rd_data = 32'd0;
         CSR_MHARTID:  w_rd_data = HART_ID;
`ifdef CSR_COUNTERS_EN
         CSR_MCYCLE,    CSR_CYCLE:    w_rd_data = w_mcycle[31:0];
         CSR_MCYCLEH,   CSR_CYCLEH:   w_rd_data = w_mcycle[63:32];
         CSR_MINSTRET,  CSR_INSTRET:  w_rd_data = w_minstret[31:0];
         CSR_MINSTRETH, CSR_INSTRETH: w_rd_data = w_minstret[63:32];
`endif
         default: begin
            w_rd_data  = 32'd0;
            w_rd_legal = 1'b0;
         end
      endcase
   end

   // Read channel FSM; a dropped arvalid before the response aborts silently.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= RD_IDLE;
         r_cnt    <= 3'd0;
         r_addr   <= 12'd0;
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         case (r_state)
            RD_IDLE: begin
               if (csrbus.csrbus_arvalid) begin
                  r_addr <= csrbus.csrbus_araddr;
                  r_cnt  <= LAT_M1;
                  if (LAT_M1 == 3'd0) begin
                     r_state  <= RD_RESP;
                     r_rvalid <= 1'b1;
                  end else begin
                     r_state <= RD_COUNT;
                  end
               end
            end
            RD_COUNT: begin
               if (!csrbus.csrbus_arvalid) begin
                  r_state <= RD_IDLE;
               end else if (r_cnt == 3'd1) begin
                  r_cnt    <= 3'd0;
                  r_state  <= RD_RESP;
                  r_rvalid <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 3'd1;
               end
            end
            RD_RESP: r_state <= RD_HOLD;
            RD_HOLD: begin
               if (!csrbus.csrbus_arvalid) begin
                  r_state <= RD_IDLE;
               end
            end
            default: r_state <= RD_IDLE;
         endcase
      end
   end

   assign csrbus.csrbus_rvalid = r_rvalid;
   assign csrbus.csrbus_rdata  = r_rvalid ? w_rd_data : 32'd0;
   assign csrbus.csrbus_rresp  = !r_rvalid ? 2'b00 : (w_rd_legal ? RRESP_OK : RRESP_ILLEGAL);
   assign mtvec_out            = r_mtvec;
   assign mepc_out             = r_mepc;
endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: two instances (read latency 1 and 3) share the write port.
module tb_csr_file;
   import csr_pkg::*;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  resp;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [11:0] wr_addr;
   logic [31:0] wr_val;
   logic        wr_valid;
   logic        instret_inc;
   logic [31:0] mtvec1, mepc1, mtvec3, mepc3;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;

   always #5 clk = ~clk;

   csr_file_if bus1 ();
   csr_file_if bus3 ();

   csr_file #(.READ_LATENCY(1), .HART_ID(32'd5)) dut (
      .clk(clk), .reset_n(reset_n), .csrbus(bus1),
      .csr_write_addr(wr_addr), .csr_write_val(wr_val), .csr_write_valid(wr_valid),
      .instret_inc(instret_inc), .mtvec_out(mtvec1), .mepc_out(mepc1)
   );

   csr_file #(.READ_LATENCY(3), .HART_ID(32'd9)) dut3 (
      .clk(clk), .reset_n(reset_n), .csrbus(bus3),
      .csr_write_addr(wr_addr), .csr_write_val(wr_val), .csr_write_valid(wr_valid),
      .instret_inc(instret_inc), .mtvec_out(mtvec3), .mepc_out(mepc3)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic rv(input int sel);
      return (sel == 1) ? bus1.csrbus_rvalid : bus3.csrbus_rvalid;
   endfunction

   task automatic set_ar(input int sel, input logic [11:0] addr, input logic v);
      if (sel == 1) begin
         bus1.csrbus_araddr  = addr;
         bus1.csrbus_arvalid = v;
      end else begin
         bus3.csrbus_araddr  = addr;
         bus3.csrbus_arvalid = v;
      end
   endtask

   task automatic do_write(input logic [11:0] addr, input logic [31:0] val);
      @(posedge clk); #1;
      wr_addr  = addr;
      wr_val   = val;
      wr_valid = 1'b1;
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   // Issue a read, queue its expected response, and check the latency; optionally
   // write 5 to the same address during the response cycle.
   task automatic do_read(input int sel, input logic [11:0] addr, input logic [31:0] ed,
                          input logic [1:0] er, input bit wr5);
      exp_t e;
      int   lat;
      bit   got;
      e.data = ed;
      e.resp = er;
      @(posedge clk); #1;
      if (sel == 1) q1.push_back(e); else q3.push_back(e);
      set_ar(sel, addr, 1'b1);
      got = 1'b0;
      lat = 0;
      for (int i = 1; i <= 12 && !got; i++) begin
         @(posedge clk); #1;
         if (rv(sel)) begin
            got = 1'b1;
            lat = i;
         end
      end
      check_eq("rv_seen", got, 1'b1);
      check_eq("latency", lat, (sel == 1) ? 1 : 3);
      if (wr5) begin
         wr_addr  = addr;
         wr_val   = 32'd5;
         wr_valid = 1'b1;
      end
      set_ar(sel, addr, 1'b0);
      @(posedge clk); #1;
      wr_valid = 1'b0;
      @(posedge clk);
   endtask

   // Response monitor: pops the scoreboard on every rvalid and checks idle zeros otherwise.
   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         if (bus1.csrbus_rvalid) begin
            if (q1.size() == 0) check_eq("extra_rv1", bus1.csrbus_rvalid, 1'b0);
            else begin
               e1 = q1.pop_front();
               check_eq("rdata1", bus1.csrbus_rdata, e1.data);
               check_eq("rresp1", bus1.csrbus_rresp, e1.resp);
            end
         end else begin
            check_eq("idle1", {bus1.csrbus_rdata, bus1.csrbus_rresp}, 34'd0);
         end
         if (bus3.csrbus_rvalid) begin
            if (q3.size() == 0) check_eq("extra_rv3", bus3.csrbus_rvalid, 1'b0);
            else begin
               e3 = q3.pop_front();
               check_eq("rdata3", bus3.csrbus_rdata, e3.data);
               check_eq("rresp3", bus3.csrbus_rresp, e3.resp);
            end
         end else begin
            check_eq("idle3", {bus3.csrbus_rdata, bus3.csrbus_rresp}, 34'd0);
         end
      end
   end

   initial begin
      int pulses;
      reset_n     = 1'b0;
      wr_addr     = 12'd0;
      wr_val      = 32'd0;
      wr_valid    = 1'b0;
      instret_inc = 1'b0;
      set_ar(1, 12'd0, 1'b0);
      set_ar(3, 12'd0, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_rvalid", {bus1.csrbus_rvalid, bus3.csrbus_rvalid}, 2'b00);
      check_eq("rst_rdata", bus1.csrbus_rdata, 32'd0);
      check_eq("rst_mtvec", mtvec1, 32'd0);
      check_eq("rst_mepc", mepc1, 32'd0);
      reset_n = 1'b1;

      do_write(CSR_MSCRATCH, 32'hDEAD_BEEF);
      do_read(1, CSR_MSCRATCH, 32'hDEAD_BEEF, RRESP_OK, 1'b0);

      do_write(CSR_MTVEC, 32'h0000_1003);
      check_eq("mtvec_out", mtvec1, 32'h0000_1000);
      do_read(1, CSR_MTVEC, 32'h0000_1000, RRESP_OK, 1'b0);
      do_write(CSR_MEPC, 32'h8000_0007);
      check_eq("mepc_out", mepc3, 32'h8000_0004);
      do_read(1, CSR_MEPC, 32'h8000_0004, RRESP_OK, 1'b0);

      do_write(CSR_MSTATUS, 32'hFFFF_FFFF);
      do_read(1, CSR_MSTATUS, 32'h0000_1888, RRESP_OK, 1'b0);
      do_write(CSR_MIE, 32'hFFFF_FFFF);
      do_read(1, CSR_MIE, 32'h0000_0888, RRESP_OK, 1'b0);
      do_write(CSR_MCAUSE, 32'hA5A5_A5A5);
      do_read(1, CSR_MCAUSE, 32'hA5A5_A5A5, RRESP_OK, 1'b0);
      do_write(CSR_MISA, 32'd0);
      do_read(1, CSR_MISA, 32'h4000_0100, RRESP_OK, 1'b0);
      do_write(CSR_MIP, 32'hFFFF_FFFF);
      do_read(1, CSR_MIP, 32'd0, RRESP_OK, 1'b0);

      do_read(1, 12'h7C0, 32'd0, RRESP_ILLEGAL, 1'b0);
      do_write(12'h7C0, 32'h1234_5678);
      do_write(CSR_MHARTID, 32'h0000_0077);
      do_read(1, CSR_MHARTID, 32'd5, RRESP_OK, 1'b0);
      do_read(3, CSR_MHARTID, 32'd9, RRESP_OK, 1'b0);
      do_read(1, CSR_MSCRATCH, 32'hDEAD_BEEF, RRESP_OK, 1'b0);

      // Abort on the latency-3 instance: arvalid held for two cycles only.
      @(posedge clk); #1;
      set_ar(3, CSR_MSCRATCH, 1'b1);
      repeat (2) begin @(posedge clk); #1; end
      set_ar(3, CSR_MSCRATCH, 1'b0);
      pulses = 0;
      repeat (6) begin @(posedge clk); #1; if (bus3.csrbus_rvalid) pulses++; end
      check_eq("abort_norv", pulses, 0);
      do_read(3, CSR_MSCRATCH, 32'hDEAD_BEEF, RRESP_OK, 1'b0);
      pulses = 0;
      repeat (6) begin @(posedge clk); #1; if (bus3.csrbus_rvalid) pulses++; end
      check_eq("single_pulse", pulses, 0);

`ifdef CSR_COUNTERS_EN
      do_write(CSR_MCYCLEH, 32'd0);
      do_write(CSR_MCYCLE, 32'hFFFF_FFFF);
      repeat (2) @(posedge clk);
      do_read(1, CSR_MCYCLEH, 32'd1, RRESP_OK, 1'b0);
      do_read(3, CSR_CYCLEH, 32'd1, RRESP_OK, 1'b0);
      do_write(CSR_MINSTRET, 32'd0);
      do_write(CSR_MINSTRETH, 32'd0);
      instret_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1 instret_inc = 1'b0;
      do_read(1, CSR_INSTRET, 32'd3, RRESP_OK, 1'b0);
      do_read(1, CSR_MINSTRETH, 32'd0, RRESP_OK, 1'b0);
`else
      instret_inc = 1'b1;
      repeat (3) @(posedge clk);
      #1 instret_inc = 1'b0;
      do_read(1, CSR_MCYCLE, 32'd0, RRESP_ILLEGAL, 1'b0);
      do_read(3, CSR_INSTRET, 32'd0, RRESP_ILLEGAL, 1'b0);
      do_write(CSR_MCYCLE, 32'h0000_00FF);
      do_read(1, CSR_MCYCLEH, 32'd0, RRESP_ILLEGAL, 1'b0);
`endif

      do_read(1, CSR_MSCRATCH, 32'hDEAD_BEEF, RRESP_OK, 1'b1);
      do_read(1, CSR_MSCRATCH, 32'd5, RRESP_OK, 1'b0);
      do_read(3, CSR_MSCRATCH, 32'd5, RRESP_OK, 1'b0);

      // Reset while rvalid is high must clear it without waiting for a clock.
      @(posedge clk); #1;
      set_ar(1, CSR_MSCRATCH, 1'b1);
      @(posedge clk); #1;
      check_eq("pre_rst_rv", bus1.csrbus_rvalid, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      check_eq("async_rv", bus1.csrbus_rvalid, 1'b0);
      check_eq("async_rdata", bus1.csrbus_rdata, 32'd0);
      check_eq("async_mtvec", mtvec1, 32'd0);
      set_ar(1, CSR_MSCRATCH, 1'b0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      do_read(1, CSR_MSCRATCH, 32'd0, RRESP_OK, 1'b0);

      repeat (4) @(posedge clk);
      check_eq("q1_empty", q1.size(), 0);
      check_eq("q3_empty", q3.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
